// File: rtl/fp_acc_sched_if.sv
// Bus between a two-requester client and the shared FP32 accumulator.
// The client side drives requests/operands; the scheduler side answers
// with ready/grant and the final sum.
interface fp_acc_sched_if #(
  parameter int LEN_W = 8
);
  logic [1:0]         req_i;
  logic [2*LEN_W-1:0] len_i;
  logic [63:0]        data_i;
  logic [1:0]         valid_i;
  logic [1:0]         ready_o;
  logic [1:0]         grant_o;
  logic [31:0]        result_o;
  logic               result_valid_o;
  logic               result_id_o;
  logic               busy_o;

  modport master (
    output req_i, len_i, data_i, valid_i,
    input  ready_o, grant_o, result_o, result_valid_o, result_id_o, busy_o
  );

  modport slave (
    input  req_i, len_i, data_i, valid_i,
    output ready_o, grant_o, result_o, result_valid_o, result_id_o, busy_o
  );
endinterface

// File: rtl/fp_acc_sched.sv
// Shared binary32 accumulator with a round-robin scheduler for two
// requesters. adder_fp holds the running sum; fp_acc_sched owns the
// arbitration, the per-transaction clear and the operand handshake.

// Binary32 accumulator: sum_o <= sum_o + summand_i on en_i, with
// round-to-nearest-even, subnormal support and Inf/NaN propagation.
// Invalid operations (Inf - Inf) and NaN inputs produce 0x7FC00000.
module adder_fp (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        en_i,
  input  logic [31:0] summand_i,
  output logic [31:0] sum_o
);
  logic [31:0] r_sum;
  logic [31:0] w_a, w_b, w_x, w_y, w_next;
  logic        w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_swap;
  logic [7:0]  w_ex, w_ey, w_d;
  logic [23:0] w_mx, w_my;
  logic [5:0]  w_sh;
  logic [49:0] w_wide;
  logic [26:0] w_big, w_small, w_m;
  logic [27:0] w_s;
  logic [4:0]  w_lz;
  logic [9:0]  w_e, w_shl, w_ef;
  logic [24:0] w_r;
  logic        w_rnd;
  logic [22:0] w_frac;

  assign w_a   = r_sum;
  assign w_b   = summand_i;
  assign sum_o = r_sum;

  // Combinational single-cycle add: align, add/sub, normalise, round.
  always_comb begin
    w_a_nan = (w_a[30:23] == 8'hFF) && (w_a[22:0] != 23'd0);
    w_b_nan = (w_b[30:23] == 8'hFF) && (w_b[22:0] != 23'd0);
    w_a_inf = (w_a[30:23] == 8'hFF) && (w_a[22:0] == 23'd0);
    w_b_inf = (w_b[30:23] == 8'hFF) && (w_b[22:0] == 23'd0);

    // x always carries the larger magnitude so the subtraction never goes negative
    w_swap = (w_b[30:0] > w_a[30:0]);
    w_x    = w_swap ? w_b : w_a;
    w_y    = w_swap ? w_a : w_b;

    // subnormals use exponent 1 with no hidden bit
    w_ex = (w_x[30:23] == 8'd0) ? 8'd1 : w_x[30:23];
    w_ey = (w_y[30:23] == 8'd0) ? 8'd1 : w_y[30:23];
    w_mx = {|w_x[30:23], w_x[22:0]};
    w_my = {|w_y[30:23], w_y[22:0]};

    // align the smaller operand; 3 extra bits = guard, round, sticky
    w_d     = w_ex - w_ey;
    w_sh    = (w_d > 8'd27) ? 6'd27 : w_d[5:0];
    w_wide  = {w_my, 26'd0} >> w_sh;
    w_big   = {w_mx, 3'b000};
    w_small = {w_wide[49:24], |w_wide[23:0]};

    if (w_x[31] == w_y[31]) begin
      w_s = {1'b0, w_big} + {1'b0, w_small};
    end else begin
      w_s = {1'b0, w_big} - {1'b0, w_small};
    end

    // leading-zero count over the 27-bit magnitude (27 when all zero)
    w_lz = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (w_s[i]) w_lz = 5'(26 - i);
    end

    w_e   = {2'b00, w_ex};
    w_shl = 10'd0;
    if (w_s[27]) begin
      // carry out: shift right once, folding the dropped bit into sticky
      w_m = {w_s[27:2], w_s[1] | w_s[0]};
      w_e = w_e + 10'd1;
    end else begin
      // left shift stops at exponent 1 so results underflow into subnormals
      if ({5'd0, w_lz} > (w_e - 10'd1)) begin
        w_shl = w_e - 10'd1;
      end else begin
        w_shl = {5'd0, w_lz};
      end
      w_m = w_s[26:0] << w_shl;
      w_e = w_e - w_shl;
    end

    w_ef  = w_m[26] ? w_e : 10'd0;
    w_rnd = w_m[2] & (w_m[1] | w_m[0] | w_m[3]);
    w_r   = {1'b0, w_m[26:3]} + {24'd0, w_rnd};
    if (w_r[24]) begin
      w_ef   = w_ef + 10'd1;
      w_frac = w_r[23:1];
    end else begin
      // a subnormal that rounds up into the hidden bit becomes normal
      if ((w_ef == 10'd0) && w_r[23]) w_ef = 10'd1;
      w_frac = w_r[22:0];
    end

    if (w_ef >= 10'd255) begin
      w_next = {w_x[31], 8'hFF, 23'd0};
    end else begin
      w_next = {w_x[31], w_ef[7:0], w_frac};
    end

    // exact zero: -0 only when both inputs are -0
    if (w_s == 28'd0) w_next = {w_x[31] & w_y[31], 31'd0};

    if (w_a_nan || w_b_nan) begin
      w_next = 32'h7FC00000;
    end else if (w_a_inf && w_b_inf) begin
      w_next = (w_a[31] != w_b[31]) ? 32'h7FC00000 : w_a;
    end else if (w_a_inf) begin
      w_next = w_a;
    end else if (w_b_inf) begin
      w_next = w_b;
    end
  end

  // Running sum register; reset also serves as the per-transaction clear.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_sum <= 32'd0;
    end else if (en_i) begin
      r_sum <= w_next;
    end
  end
endmodule

// Two-requester round-robin scheduler in front of one adder_fp.
module fp_acc_sched #(
  parameter int LEN_W = 8
) (
  input logic           clk_i,
  input logic           rst_n_i,
  fp_acc_sched_if.slave bus
);
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_ACCUM,
    ST_DONE
  } state_t;

  state_t           r_state;
  logic             r_rr;
  logic             r_gid;
  logic             r_clr;
  logic             r_busy;
  logic             r_result_valid;
  logic             r_result_id;
  logic [1:0]       r_grant;
  logic [1:0]       r_ready;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_cnt;

  logic [LEN_W-1:0] w_len [2];
  logic [31:0]      w_data [2];
  logic             w_win;
  logic             w_accept;
  logic [LEN_W:0]   w_cnt_inc;
  logic             w_last;
  logic             w_acc_en;
  logic             w_acc_rst_n;
  logic [31:0]      w_summand;
  logic [31:0]      w_sum;

  // per-requester views of the packed length/data buses
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_req
      assign w_len[gi]  = bus.len_i[gi*LEN_W +: LEN_W];
      assign w_data[gi] = bus.data_i[gi*32 +: 32];
    end
  endgenerate

  // rr_ptr wins when it requests, otherwise the other requester does
  assign w_win = bus.req_i[r_rr] ? r_rr : ~r_rr;

  // ready is only ever set for the granted requester while accumulating
  assign w_accept  = bus.valid_i[r_gid] & r_ready[r_gid];
  assign w_cnt_inc = {1'b0, r_cnt} + {{LEN_W{1'b0}}, 1'b1};
  assign w_last    = (w_cnt_inc == {1'b0, r_len});

  assign w_acc_en    = w_accept;
  assign w_summand   = w_data[r_gid];
  // r_clr is a flop output, so the derived reset is glitch-free
  assign w_acc_rst_n = rst_n_i & ~r_clr;

  adder_fp u_acc (
    .clk_i     (clk_i),
    .rst_n_i   (w_acc_rst_n),
    .en_i      (w_acc_en),
    .summand_i (w_summand),
    .sum_o     (w_sum)
  );

  // Scheduler FSM with all control outputs registered.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state        <= ST_IDLE;
      r_rr           <= 1'b0;
      r_gid          <= 1'b0;
      r_clr          <= 1'b0;
      r_busy         <= 1'b0;
      r_result_valid <= 1'b0;
      r_result_id    <= 1'b0;
      r_grant        <= 2'b00;
      r_ready        <= 2'b00;
      r_len          <= '0;
      r_cnt          <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_result_valid <= 1'b0;
          if (|bus.req_i) begin
            r_gid   <= w_win;
            r_len   <= w_len[w_win];
            r_rr    <= ~w_win;
            r_grant <= w_win ? 2'b10 : 2'b01;
            r_clr   <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          r_clr <= 1'b0;
          r_cnt <= '0;
          if (r_len != '0) begin
            r_ready <= r_grant;
            r_state <= ST_ACCUM;
          end else begin
            r_result_valid <= 1'b1;
            r_result_id    <= r_gid;
            r_state        <= ST_DONE;
          end
        end
        ST_ACCUM: begin
          if (w_accept) begin
            r_cnt <= w_cnt_inc[LEN_W-1:0];
            if (w_last) begin
              r_ready        <= 2'b00;
              r_result_valid <= 1'b1;
              r_result_id    <= r_gid;
              r_state        <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          r_result_valid <= 1'b0;
          r_grant        <= 2'b00;
          r_busy         <= 1'b0;
          r_state        <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.ready_o        = r_ready;
  assign bus.grant_o        = r_grant;
  assign bus.result_o       = w_sum;
  assign bus.result_valid_o = r_result_valid;
  assign bus.result_id_o    = r_result_id;
  assign bus.busy_o         = r_busy;
endmodule

// File: doc/fp_acc_sched.md
FP_ACC_SCHED -- requirements
Module: fp_acc_sched

Parameters
REQ-001 SHALL have parameter LEN_W, default 8, width of the per-requester operand-count field.

Interface
REQ-002 SHALL have port clk_i  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst_n_i  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port req_i  input  2  per-requester accumulation request; bit k = requester k.
REQ-005 SHALL have port len_i  input  2*LEN_W  operand count per requester; bits [k*LEN_W +: LEN_W] = requester k.
REQ-006 SHALL have port data_i  input  64  IEEE-754 binary32 operand per requester; bits [k*32 +: 32] = requester k.
REQ-007 SHALL have port valid_i  input  2  operand-valid per requester.
REQ-008 SHALL have port ready_o  output  2  operand-ready per requester.
REQ-009 SHALL have port grant_o  output  2  one-hot (or zero) ownership of the accumulator.
REQ-010 SHALL have port result_o  output  32  binary32 final sum.
REQ-011 SHALL have port result_valid_o  output  1  one-cycle result strobe.
REQ-012 SHALL have port result_id_o  output  1  requester index owning result_o.
REQ-013 SHALL have port busy_o  output  1  high in every state except IDLE.

Function
REQ-014 SHALL instantiate one adder_fp accumulator and drive:
- its en_i and summand_i from the granted requester;
- its rst_n_i = rst_n_i AND NOT clr_q, where clr_q is a flop output (glitch-free).
REQ-015 SHALL implement FSM states IDLE, CLEAR, ACCUM, DONE.
REQ-016 IDLE: if any req_i bit is set:
- grant by round-robin, preferring requester rr_ptr;
- latch the granted index and len_i[granted];
- set rr_ptr to the other requester;
- go to CLEAR.
Otherwise stay in IDLE.
REQ-017 CLEAR: clr_q high for exactly this one cycle, so the accumulator sum is forced to 0x00000000; next state ACCUM if latched len != 0, else DONE.
REQ-018 ACCUM:
- ready_o[g] = 1 for the granted g only;
- accept when valid_i[g] & ready_o[g]; on accept pulse adder en_i = 1 with summand_i = data_i[g];
- no en_i pulse without an accept;
- increment operand counter on each accept;
- after the len-th accept go to DONE.
REQ-019 ACCUM SHALL tolerate arbitrary valid_i gaps: no accept, no en_i, counter unchanged, state held.
REQ-020 DONE:
- result_valid_o = 1 for exactly one cycle;
- result_o = accumulator sum_o, reflecting all len operands;
- result_id_o = g;
- next state IDLE.
REQ-021 Latency: result_valid_o SHALL assert in the cycle immediately after the final accept; for len = 0, two cycles after grant, with result_o = 0x00000000.
REQ-022 grant_o[g] SHALL be high from CLEAR through DONE inclusive and 0 in IDLE.
REQ-023 ready_o SHALL be 0 outside ACCUM.
REQ-024 Ignored inputs:
- req_i changes after grant are ignored until return to IDLE;
- len_i is sampled only at grant;
- data_i/valid_i of the non-granted requester are ignored.
REQ-025 Both req_i bits high in IDLE SHALL grant rr_ptr; consecutive contended transactions alternate 0,1,0,1.
REQ-026 A request present in the DONE cycle SHALL be granted no earlier than the following IDLE cycle (one idle cycle between transactions).
REQ-027 Arithmetic (round-to-nearest-even, Inf/NaN propagation) is that of adder_fp; the controller SHALL NOT modify operands or results.
REQ-028 Operand counter SHALL be LEN_W bits wide and SHALL NOT wrap; len = 2^LEN_W-1 is the maximum.

Reset
REQ-029 On rst_n_i low, asynchronously:
- FSM = IDLE, rr_ptr = 0, counter = 0, clr_q = 0;
- grant_o = 0, ready_o = 0, result_valid_o = 0, result_id_o = 0, busy_o = 0;
- result_o = 0x00000000 (accumulator reset).
REQ-030 Reset asserted mid-transaction SHALL abandon the transaction with no result_valid_o; after release the block SHALL wait in IDLE for a fresh req_i.

Verification
REQ-031 Req0 with len=3, operands 0x3F800000, 0x40000000, 0x40400000 -> result_o=0x40C00000, result_id_o=0, result_valid_o one cycle after the third accept.
REQ-032 req_i=2'b11 held, both len=2:
- req0 operands 1.0, 1.0; req1 operands 0x40A00000, 0x40A00000;
- grants in order 0,1,0;
- results 0x40000000 then 0x41200000;
- second result is not contaminated by the first (CLEAR verified).
REQ-033 Req1 with len=0 -> grant, CLEAR, DONE; result_o=0x00000000, result_id_o=1, ready_o never asserted.
REQ-034 Req0 with len=4, operands 1.0 each, valid_i toggling every other cycle -> exactly 4 en_i pulses; result 0x40800000.
REQ-035 rst_n_i pulsed low after 2 of 4 accepts -> no result_valid_o, all outputs at reset values; a subsequent req1 with len=1 and operand 0xC0000000 -> result 0xC0000000.
